cla_adder_pipe: RTL
===================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit CLA.
//  Built from 4-bit lookahead groups with group generate/propagate; groups split evenly across STAGES register stages.
//  valid/ready handshake on both sides, signed overflow and zero flags; sits in the ALU/address-gen datapath.
// PARAMETERS
//  WIDTH   32  operand width; multiple of 4, >= 8
//  STAGES  2   pipeline register stages, 1..WIDTH/4; WIDTH/4 must be divisible by STAGES
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      adder accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: a - b (a + ~b + 1); 0: a + b + cin
//  cin        in   1      carry-in, ignored when sub=1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed (two's complement) overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0; out_valid=0, sum=0, cout=0, ovf=0, zero=0.
//  - Per group: g=a&b', p=a^b' (b'=b^{WIDTH{sub}}); carries by full 4-bit lookahead; group G/P chained per stage.
//  - Stage k (0..STAGES-1) resolves groups k*GPS..(k+1)*GPS-1, GPS=WIDTH/4/STAGES; registers carry into the next
//    stage, sum bits done so far, and the remaining a/b'/sub bits. No ripple through any stage beyond GPS groups.
//  - Handshake: stage i holds valid_i; ready_i = !valid_i | ready_(i+1); last stage ready = out_ready.
//    in_ready = ready_0. Beat accepted when in_valid & in_ready; result appears STAGES cycles later if unstalled.
//  - Full throughput: one beat/cycle when out_ready held 1; bubbles collapse (an empty stage always accepts).
//  - Stall: out_valid & !out_ready holds sum/cout/ovf/zero stable; upstream stages fill then in_ready drops.
//  - Input bus values are don't-care when in_valid=0; stage registers do not load when not advancing.
//  - ovf = (a[MSB] == b'[MSB]) & (sum[MSB] != a[MSB]); zero computed on final (post-saturation) sum.
//  - Ordering strictly FIFO; no beat dropped or duplicated; simultaneous accept and emit allowed same cycle.
//  - rst_n asserted mid-operation discards every in-flight beat immediately; out_valid falls asynchronously.
//  - Edge cases: 0xFFFFFFFF+1 -> sum 0, cout 1, zero 1; a-a -> 0, cout 1, ovf 0; cin=1,sub=1 same as cin=0.
// CONFIGURATION
//  CLA_ADD_SATURATE_EN defined: extra input sat (1 bit, sampled with the beat, pipelined with it); when sat=1
//   and ovf=1, sum clamps to 0x7FF..F if a[MSB]=0 else 0x800..0; ovf still reports 1, cout unclamped.
//   sat=0 behaves exactly as the undefined build.
//  CLA_ADD_SATURATE_EN undefined: no sat port, sum always wraps modulo 2^WIDTH.
// TESTING  (WIDTH=32, STAGES=2 unless noted)
//  - Reset: rst_n=0 mid-stream with 2 beats in flight -> out_valid=0 at once, no output after release until new input.
//  - Add: a=0xFFFFFFFF,b=1,cin=0 -> sum=0,cout=1,zero=1,ovf=0 exactly 2 cycles after accept; a=0x7FFFFFFF,b=1 -> ovf=1.
//  - Sub: a=5,b=7,sub=1 -> sum=0xFFFFFFFE,cout=0; a=0x80000000,b=1,sub=1 -> sum=0x7FFFFFFF,ovf=1.
//  - Back-pressure: 4 beats back-to-back, out_ready=0 for 5 cycles -> in_ready low after 2 accepts, order intact, sum stable.
//  - Random: 10k random a/b/sub/cin with random in_valid/out_ready, STAGES in {1,2,4,8} -> matches reference model, 1 beat/cycle when unstalled.
//  - CLA_ADD_SATURATE_EN: a=0x7FFFFFFF,b=1,sat=1 -> sum=0x7FFFFFFF,ovf=1; a=0x80000000,b=1,sub=1,sat=1 -> sum=0x80000000.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Optional clamp-on-overflow mode is enabled by defining CLA_ADD_SATURATE_EN (adds the sat input).
module cla_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef CLA_ADD_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG  = WIDTH / 4;
  localparam int GPS = NG / STAGES;
  localparam int SW  = 4 * GPS;

  // Returns {carry_out, sum[3:0]}; carry_out formed from group G/P, not rippled.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g, p, c;
    logic       gg, pp;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    return {gg | (pp & ci), p ^ c};
  endfunction

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vld;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = vld[STAGES-1];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Operand bits not yet consumed when entering this stage.
    localparam int RIN = WIDTH - gi * SW;

    logic [RIN-1:0]         a_in, bx_in;
    logic                   c_in, v_in, v_q, c_out, cc;
    logic [SW-1:0]          gsum;
    logic [(gi+1)*SW-1:0]   nsum;
    logic [4:0]             t;
`ifdef CLA_ADD_SATURATE_EN
    logic                   sat_in;
`endif

    if (gi == 0) begin : g_src
      assign a_in  = a;
      assign bx_in = b ^ {WIDTH{sub}};
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign nsum  = gsum;
`ifdef CLA_ADD_SATURATE_EN
      assign sat_in = sat;
`endif
    end else begin : g_src
      assign a_in  = g_stage[gi-1].g_mid.a_q;
      assign bx_in = g_stage[gi-1].g_mid.bx_q;
      assign c_in  = g_stage[gi-1].g_mid.c_q;
      assign v_in  = vld[gi-1];
      assign nsum  = {gsum, g_stage[gi-1].g_mid.sum_q};
`ifdef CLA_ADD_SATURATE_EN
      assign sat_in = g_stage[gi-1].g_mid.sat_q;
`endif
    end

    always_comb begin
      cc   = c_in;
      gsum = '0;
      t    = '0;
      for (int j = 0; j < GPS; j++) begin
        t              = cla4(a_in[j*4 +: 4], bx_in[j*4 +: 4], cc);
        gsum[j*4 +: 4] = t[3:0];
        cc             = t[4];
      end
      c_out = cc;
    end

    assign rdy[gi] = ~v_q | rdy[gi+1];
    assign vld[gi] = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       v_q <= 1'b0;
      else if (rdy[gi]) v_q <= v_in;
    end

    if (gi < STAGES - 1) begin : g_mid
      logic [RIN-SW-1:0]    a_q, bx_q;
      logic [(gi+1)*SW-1:0] sum_q;
      logic                 c_q;
`ifdef CLA_ADD_SATURATE_EN
      logic                 sat_q;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          bx_q  <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
`ifdef CLA_ADD_SATURATE_EN
          sat_q <= 1'b0;
`endif
        end else if (rdy[gi] && v_in) begin
          a_q   <= a_in[RIN-1:SW];
          bx_q  <= bx_in[RIN-1:SW];
          sum_q <= nsum;
          c_q   <= c_out;
`ifdef CLA_ADD_SATURATE_EN
          sat_q <= sat_in;
`endif
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] fsum, sum_q;
      logic             ovf_w, cout_q, ovf_q, zero_q;

      // Flags and clamp are resolved before the final register so outputs are stable under stall.
      always_comb begin
        ovf_w = (a_in[RIN-1] == bx_in[RIN-1]) & (nsum[WIDTH-1] != a_in[RIN-1]);
        fsum  = nsum;
`ifdef CLA_ADD_SATURATE_EN
        if (sat_in && ovf_w)
          fsum = a_in[RIN-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (rdy[gi] && v_in) begin
          sum_q  <= fsum;
          cout_q <= c_out;
          ovf_q  <= ovf_w;
          zero_q <= (fsum == '0);
        end
      end

      assign sum  = sum_q;
      assign cout = cout_q;
      assign ovf  = ovf_q;
      assign zero = zero_q;
    end
  end
endmodule
